// File: rtl/reg_io_bridge_pkg.sv
// Shared types and constants for reg_io_bridge: input FSM states, hex decode table, digit count.
// Pure declarations; no logic, no latency, no flow control.
// Used by reg_io_bridge and hex_to_seg7 via import reg_io_bridge_pkg::*.
package reg_io_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PULSE    = 2'd2,
        ST_HOLD     = 2'd3
    } in_state_t;

    localparam int NUM_DIGITS = 8;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/reg_io_bridge_hex_to_seg7.sv
// Purpose: hex nibble to active-low seven-segment pattern (dp off).
// Latency: purely combinational, zero cycles.
// Backpressure: none, output follows input continuously.
module hex_to_seg7
    import reg_io_bridge_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/reg_io_bridge.sv
// Purpose: switch-to-$t9 injector behind a debounced button, plus 8-digit hex display of $t8/$k0.
// Latency: outter_input fires 2 + DEBOUNCE_CYCLES + 1 cycles after a press; display is free-running.
// Backpressure: none; one strobe per press. SW_SIGN_EXT_EN selects sign- vs zero-extension of sw.
module reg_io_bridge
    import reg_io_bridge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int SCAN_DIV        = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        confirm_btn,
    input  logic        display_sel,
    input  logic [31:0] ram_reg_i,
    input  logic [31:0] ram_reg_i2,
    output logic        outter_input,
    output logic [31:0] outter_t9,
    output logic        busy,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int DIG_W  = $clog2(NUM_DIGITS);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic              btn_meta;
    logic              btn_s;
    in_state_t         state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [31:0]       sw_ext;
    logic [SCAN_W-1:0] scan_cnt;
    logic [DIG_W-1:0]  digit_idx;
    logic [31:0]       snapshot;
    logic [3:0]        cur_nibble;

`ifdef SW_SIGN_EXT_EN
    assign sw_ext = {{16{sw[15]}}, sw};
`else
    assign sw_ext = {16'h0000, sw};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= confirm_btn;
            btn_s    <= btn_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            deb_cnt      <= '0;
            outter_input <= 1'b0;
            outter_t9    <= '0;
            busy         <= 1'b0;
        end else begin
            outter_input <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (btn_s) begin
                        state   <= ST_DEBOUNCE;
                        deb_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!btn_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state        <= ST_PULSE;
                        outter_input <= 1'b1;
                        outter_t9    <= sw_ext;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                ST_PULSE: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Stay here while held so a long press yields one strobe only.
                    if (!btn_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            snapshot  <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (digit_idx == DIG_LAST) begin
                digit_idx <= '0;
                // Refresh only at scan start so all eight digits come from one value.
                snapshot  <= display_sel ? ram_reg_i2 : ram_reg_i;
            end else begin
                digit_idx <= digit_idx + DIG_W'(1);
            end
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        seg_an            = '1;
        seg_an[digit_idx] = 1'b0;
    end

    assign cur_nibble = snapshot[{digit_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex (cur_nibble),
        .seg (seg_out)
    );

endmodule

// File: tb/tb_reg_io_bridge.sv
// Bench for reg_io_bridge with DEBOUNCE_CYCLES=4, SCAN_DIV=3: press/glitch/reset scenarios
// and a scan-position display model, with randomized switch and register values.
module tb_reg_io_bridge;

    localparam int DEB  = 4;
    localparam int SDIV = 3;
    localparam int SCAN = SDIV * 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic        confirm_btn;
    logic        display_sel;
    logic [31:0] ram_reg_i;
    logic [31:0] ram_reg_i2;
    logic        outter_input;
    logic [31:0] outter_t9;
    logic        busy;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_t9  = 32'h0;

    reg_io_bridge #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
        .clock        (clock),
        .reset        (reset),
        .sw           (sw),
        .confirm_btn  (confirm_btn),
        .display_sel  (display_sel),
        .ram_reg_i    (ram_reg_i),
        .ram_reg_i2   (ram_reg_i2),
        .outter_input (outter_input),
        .outter_t9    (outter_t9),
        .busy         (busy),
        .seg_an       (seg_an),
        .seg_out      (seg_out)
    );

    always #5 clock = ~clock;

    // Display reference: cycles since reset give the scan position; a new
    // snapshot of the selected register is taken every full scan.
    int          n_cyc;
    logic [31:0] snap_m;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_cyc  <= 0;
            snap_m <= 32'h0;
        end else begin
            n_cyc <= n_cyc + 1;
            if ((n_cyc + 1) % SCAN == 0)
                snap_m <= display_sel ? ram_reg_i2 : ram_reg_i;
        end
    end

    function automatic logic [7:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  4'hF: return 8'h8E;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] ext(input logic [15:0] s);
`ifdef SW_SIGN_EXT_EN
        return {{16{s[15]}}, s};
`else
        return {16'h0000, s};
`endif
    endfunction

    // Holds the button for k cycles and reports what the DUT did.
    task automatic press(input int k, input logic [15:0] swv, output int pulses,
                         output int first_at, output logic [31:0] t9_at, output logic busy_mid);
        pulses = 0; first_at = -1; t9_at = '0; busy_mid = 1'b0;
        @(negedge clock);
        confirm_btn = 1'b1;
        sw = swv;
        for (int c = 1; c <= k + 12; c++) begin
            @(negedge clock);
            if (c == 4) busy_mid = busy;
            if (outter_input === 1'b1) begin
                if (pulses == 0) begin
                    first_at = c;
                    t9_at    = outter_t9;
                end
                pulses++;
            end
            if (c == k) confirm_btn = 1'b0;
            if (c >= 9) sw = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; confirm_btn = 1'b0; sw = 16'h0; display_sel = 1'b0;
        ram_reg_i = 32'h0; ram_reg_i2 = 32'h0;
        #1;
        vectors++; if (outter_input !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", outter_input); end
        vectors++; if (outter_t9 !== 32'h0) begin errors++; $display("FAIL reset_t9 got=%h exp=0", outter_t9); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (seg_an !== 8'hFE) begin errors++; $display("FAIL reset_an got=%h exp=fe", seg_an); end
        vectors++; if (seg_out !== 8'hC0) begin errors++; $display("FAIL reset_seg got=%h exp=c0", seg_out); end
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_press_hold();
        int p, f; logic [31:0] t; logic b;
        press(10, 16'h00A5, p, f, t, b);
        exp_t9 = 32'h000000A5;
        vectors++; if (p != 1) begin errors++; $display("FAIL hold_pulses got=%0d exp=1", p); end
        vectors++; if (f < 6 || f > 8) begin errors++; $display("FAIL hold_latency got=%0d exp=6..8", f); end
        vectors++; if (t !== 32'h000000A5) begin errors++; $display("FAIL hold_t9 got=%h exp=000000a5", t); end
        vectors++; if (b !== 1'b1) begin errors++; $display("FAIL hold_busy_mid got=%b exp=1", b); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_end got=%b exp=0", busy); end
        vectors++; if (outter_t9 !== exp_t9) begin errors++; $display("FAIL hold_t9_kept got=%h exp=%h", outter_t9, exp_t9); end
    endtask

    task automatic test_glitch();
        int p, f; logic [31:0] t; logic b;
        press(2, 16'($urandom), p, f, t, b);
        vectors++; if (p != 0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=0", p); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", busy); end
        vectors++; if (outter_t9 !== exp_t9) begin errors++; $display("FAIL glitch_t9 got=%h exp=%h", outter_t9, exp_t9); end
        press(4, 16'($urandom), p, f, t, b);
        vectors++; if (p != 0) begin errors++; $display("FAIL short4_pulses got=%0d exp=0", p); end
        press(5, 16'h3C5A, p, f, t, b);
        exp_t9 = ext(16'h3C5A);
        vectors++; if (p != 1) begin errors++; $display("FAIL min5_pulses got=%0d exp=1", p); end
        vectors++; if (t !== exp_t9) begin errors++; $display("FAIL min5_t9 got=%h exp=%h", t, exp_t9); end
    endtask

    task automatic test_sign_ext();
        int p, f; logic [31:0] t; logic b; logic [31:0] req;
`ifdef SW_SIGN_EXT_EN
        req = 32'hFFFF8001;
`else
        req = 32'h00008001;
`endif
        press(10, 16'h8001, p, f, t, b);
        exp_t9 = req;
        vectors++; if (p != 1) begin errors++; $display("FAIL sext_pulses got=%0d exp=1", p); end
        vectors++; if (t !== req) begin errors++; $display("FAIL sext_t9 got=%h exp=%h", t, req); end
    endtask

    task automatic test_random_presses();
        int p, f, k; logic [31:0] t; logic b; logic [15:0] s;
        for (int i = 0; i < 10; i++) begin
            k = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(7, 14);
            s = 16'($urandom);
            press(k, s, p, f, t, b);
            if (k >= 5) begin
                exp_t9 = ext(s);
                vectors++; if (p != 1) begin errors++; $display("FAIL rnd_pulses k=%0d got=%0d exp=1", k, p); end
                vectors++; if (t !== exp_t9) begin errors++; $display("FAIL rnd_t9 got=%h exp=%h", t, exp_t9); end
                vectors++; if (f < 6 || f > 8) begin errors++; $display("FAIL rnd_latency got=%0d exp=6..8", f); end
            end else begin
                vectors++; if (p != 0) begin errors++; $display("FAIL rnd_glitch k=%0d got=%0d exp=0", k, p); end
            end
            vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy got=%b exp=0", busy); end
            vectors++; if (outter_t9 !== exp_t9) begin errors++; $display("FAIL rnd_t9_kept got=%h exp=%h", outter_t9, exp_t9); end
        end
    endtask

    task automatic test_reset_mid();
        int got, pulses;
        // Reset while the strobe is high.
        @(negedge clock);
        confirm_btn = 1'b1;
        sw = 16'($urandom);
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (outter_input === 1'b1) begin got = 1; break; end
        end
        vectors++; if (got == 0) begin errors++; $display("FAIL rstp_wait got=timeout exp=strobe"); end
        reset = 1'b0;
        #1;
        vectors++; if (outter_input !== 1'b0) begin errors++; $display("FAIL rstp_strobe got=%b exp=0", outter_input); end
        vectors++; if (outter_t9 !== 32'h0) begin errors++; $display("FAIL rstp_t9 got=%h exp=0", outter_t9); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstp_busy got=%b exp=0", busy); end
        exp_t9 = 32'h0;
        confirm_btn = 1'b0;
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (outter_input === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0) begin errors++; $display("FAIL rstp_late got=%0d exp=0", pulses); end
        // Reset while still debouncing.
        confirm_btn = 1'b1;
        for (int c = 0; c < 4; c++) @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstd_busy got=%b exp=0", busy); end
        confirm_btn = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (outter_input === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0) begin errors++; $display("FAIL rstd_late got=%0d exp=0", pulses); end
        vectors++; if (outter_t9 !== 32'h0) begin errors++; $display("FAIL rstd_t9 got=%h exp=0", outter_t9); end
    endtask

    task automatic test_display_fixed();
        logic [31:0] val;
        int d, found;
        logic [7:0] ea, es;
        ram_reg_i   = 32'h1234ABCD;
        ram_reg_i2  = 32'($urandom);
        display_sel = 1'b0;
        @(negedge clock);
        found = 0;
        for (int c = 0; c < SCAN + 2; c++) begin
            if (n_cyc % SCAN == 0) begin found = 1; break; end
            @(negedge clock);
        end
        vectors++; if (found == 0) begin errors++; $display("FAIL disp_align got=timeout exp=scan_start"); end
        val = 32'h1234ABCD;
        for (int sc = 0; sc < 2; sc++) begin
            for (int j = 0; j < SCAN; j++) begin
                d  = j / SDIV;
                ea = ~(8'h01 << d);
                es = hex7(val[4*d +: 4]);
                vectors++; if (seg_an !== ea) begin errors++; $display("FAIL disp_an scan=%0d j=%0d got=%h exp=%h", sc, j, seg_an, ea); end
                vectors++; if (seg_out !== es) begin errors++; $display("FAIL disp_seg scan=%0d j=%0d got=%h exp=%h", sc, j, seg_out, es); end
                if (sc == 0 && j == 3 * SDIV) ram_reg_i = 32'h89EF0567;
                @(negedge clock);
            end
            val = 32'h89EF0567;
        end
    endtask

    task automatic test_display_random();
        int d;
        logic [7:0] ea, es;
        display_sel = 1'b1;
        ram_reg_i2  = 32'($urandom);
        for (int c = 0; c < 150; c++) begin
            @(negedge clock);
            d  = (n_cyc % SCAN) / SDIV;
            ea = ~(8'h01 << d);
            es = hex7(snap_m[4*d +: 4]);
            vectors++; if (seg_an !== ea) begin errors++; $display("FAIL rdisp_an c=%0d got=%h exp=%h", c, seg_an, ea); end
            vectors++; if (seg_out !== es) begin errors++; $display("FAIL rdisp_seg c=%0d got=%h exp=%h", c, seg_out, es); end
            if ($urandom_range(0, 7) == 0) display_sel = ~display_sel;
            if ($urandom_range(0, 5) == 0) ram_reg_i = 32'($urandom);
            if ($urandom_range(0, 5) == 0) ram_reg_i2 = 32'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_press_hold();
        test_glitch();
        test_sign_ext();
        test_random_presses();
        test_reset_mid();
        test_display_fixed();
        test_display_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
